// File: rtl/alu_seq.sv
// EX-stage execute unit: single-cycle logic/arithmetic ops and an iterative
// 1-bit-per-cycle shifter, with valid/ready handshakes on both sides.
module alu_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_ip,
  output logic            in_ready_op,
  input  logic [3:0]      aluctrl_ip,
  input  logic [XLEN-1:0] op_a_ip,
  input  logic [XLEN-1:0] op_b_ip,
  output logic            out_valid_op,
  input  logic            out_ready_ip,
  output logic [XLEN-1:0] result_op,
  output logic            zero_op,
  output logic            illegal_op
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 illegal_q, illegal_d;
  logic [XLEN-1:0]      shreg_q, shreg_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic                 sh_left_q, sh_left_d;
  logic                 sh_arith_q, sh_arith_d;

  logic [XLEN-1:0]      alu_res_c;
  logic                 alu_ill_c;
  logic                 is_shift_c;
  logic [SHAMT_W-1:0]   shamt_c;
  logic [XLEN-1:0]      shifted_c;
  logic                 accept_c;

  assign shamt_c    = op_b_ip[SHAMT_W-1:0];
  assign is_shift_c = (aluctrl_ip == OP_SLL) || (aluctrl_ip == OP_SRL) ||
                      (aluctrl_ip == OP_SRA);

  assign in_ready_op  = (state_q == IDLE) || ((state_q == DONE) && out_ready_ip);
  assign accept_c     = in_valid_ip && in_ready_op;
  assign out_valid_op = (state_q == DONE);
  assign result_op    = result_q;
  assign zero_op      = zero_q;
  assign illegal_op   = illegal_q;

  // Single-cycle result; shift codes only reach here with a zero shift amount
  always_comb begin
    alu_res_c = '0;
    alu_ill_c = 1'b0;
    case (aluctrl_ip)
      OP_ADD:  alu_res_c = op_a_ip + op_b_ip;
      OP_SUB:  alu_res_c = op_a_ip - op_b_ip;
      OP_SLT:  alu_res_c = {{(XLEN-1){1'b0}}, ($signed(op_a_ip) < $signed(op_b_ip))};
      OP_SLTU: alu_res_c = {{(XLEN-1){1'b0}}, (op_a_ip < op_b_ip)};
      OP_XOR:  alu_res_c = op_a_ip ^ op_b_ip;
      OP_OR:   alu_res_c = op_a_ip | op_b_ip;
      OP_AND:  alu_res_c = op_a_ip & op_b_ip;
      OP_SLL, OP_SRL, OP_SRA: alu_res_c = op_a_ip;
      default: alu_ill_c = 1'b1;
    endcase
  end

  // One-bit step of the iterative shifter
  always_comb begin
    shifted_c = shreg_q;
    if (sh_left_q) begin
      shifted_c = {shreg_q[XLEN-2:0], 1'b0};
    end else begin
      shifted_c = {(sh_arith_q & shreg_q[XLEN-1]), shreg_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    illegal_d  = illegal_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    sh_left_d  = sh_left_q;
    sh_arith_d = sh_arith_q;
    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready_ip) begin
          state_d = IDLE;
        end
        if (accept_c) begin
          if (is_shift_c && (shamt_c != '0)) begin
            state_d    = SHIFT;
            shreg_d    = op_a_ip;
            cnt_d      = shamt_c;
            sh_left_d  = (aluctrl_ip == OP_SLL);
            sh_arith_d = (aluctrl_ip == OP_SRA);
          end else begin
            state_d   = DONE;
            result_d  = alu_res_c;
            zero_d    = (alu_res_c == '0);
            illegal_d = alu_ill_c;
          end
        end
      end
      SHIFT: begin
        shreg_d = shifted_c;
        cnt_d   = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d   = DONE;
          result_d  = shifted_c;
          zero_d    = (shifted_c == '0);
          illegal_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      sh_left_q  <= 1'b0;
      sh_arith_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      illegal_q  <= illegal_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      sh_left_q  <= sh_left_d;
      sh_arith_q <= sh_arith_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a reference model queues expected results and
// latencies on each accepted request; a negedge monitor checks them on output.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid_ip;
  logic        in_ready_op;
  logic [3:0]  aluctrl_ip;
  logic [31:0] op_a_ip;
  logic [31:0] op_b_ip;
  logic        out_valid_op;
  logic        out_ready_ip;
  logic [31:0] result_op;
  logic        zero_op;
  logic        illegal_op;

  alu_seq #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_ip  (in_valid_ip),
    .in_ready_op  (in_ready_op),
    .aluctrl_ip   (aluctrl_ip),
    .op_a_ip      (op_a_ip),
    .op_b_ip      (op_b_ip),
    .out_valid_op (out_valid_op),
    .out_ready_ip (out_ready_ip),
    .result_op    (result_op),
    .zero_op      (zero_op),
    .illegal_op   (illegal_op)
  );

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   first = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sh;
    sh    = int'(b[4:0]);
    e.res = 32'h0;
    e.ill = 1'b0;
    e.lat = 1;
    e.acc = 0;
    case (op)
      4'b0000: e.res = a + b;
      4'b1000: e.res = a - b;
      4'b0001: e.res = a << sh;
      4'b0010: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: e.res = (a < b) ? 32'd1 : 32'd0;
      4'b0100: e.res = a ^ b;
      4'b0101: e.res = a >> sh;
      4'b1101: e.res = 32'($signed(a) >>> sh);
      4'b0110: e.res = a | b;
      4'b0111: e.res = a & b;
      default: e.ill = 1'b1;
    endcase
    if ((op == 4'b0001 || op == 4'b0101 || op == 4'b1101) && sh != 0) e.lat = sh + 1;
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  // Scoreboard push on accept, latency check on first valid cycle, pop on handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      first = 1'b1;
    end else begin
      if (in_valid_ip && in_ready_op) begin
        e = model(aluctrl_ip, op_a_ip, op_b_ip);
        e.acc = cyc + 1;
        q.push_back(e);
      end
      if (out_valid_op) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          if (first) chk("latency", 32'(cyc - q[0].acc + 1), 32'(q[0].lat));
          if (out_ready_ip) begin
            e = q.pop_front();
            chk("result", result_op, e.res);
            chk("zero", 32'(zero_op), 32'(e.zero));
            chk("illegal", 32'(illegal_op), 32'(e.ill));
          end
        end
        first = out_ready_ip;
      end else begin
        first = 1'b1;
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int waits);
    aluctrl_ip  = op;
    op_a_ip     = a;
    op_b_ip     = b;
    in_valid_ip = 1'b1;
    waits       = 0;
    @(negedge clk);
    while (!in_ready_op && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready_op) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid_ip = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) return;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  logic [3:0] ops [11] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                           4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1001};

  initial begin
    int w;
    int stale;
    rst_n        = 1'b0;
    in_valid_ip  = 1'b0;
    out_ready_ip = 1'b0;
    aluctrl_ip   = 4'h0;
    op_a_ip      = 32'h0;
    op_b_ip      = 32'h0;
    #2;
    chk("rst_valid", 32'(out_valid_op), 32'd0);
    chk("rst_result", result_op, 32'h0);
    chk("rst_zero", 32'(zero_op), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_ready", 32'(in_ready_op), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready_ip = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops
    send(4'b0000, 32'h7FFFFFFF, 32'h1, w);        drain();
    send(4'b1000, 32'd5, 32'd5, w);               drain();
    send(4'b0010, 32'hFFFFFFFF, 32'd1, w);        drain();
    send(4'b0011, 32'hFFFFFFFF, 32'd1, w);        drain();
    send(4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, w); drain();
    send(4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, w); drain();
    send(4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, w); drain();

    // Shifts, with ready low while shifting
    send(4'b1101, 32'h80000000, 32'd31, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ready_in_shift", 32'(in_ready_op), 32'd0);
    end
    drain();
    send(4'b0101, 32'h80000000, 32'd31, w);       drain();
    send(4'b0001, 32'h1, 32'd0, w);               drain();

    // Backpressure: result held, then release together with a new request
    out_ready_ip = 1'b0;
    send(4'b0000, 32'd1, 32'd2, w);
    for (int i = 0; i < 10 && !out_valid_op; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid_op), 32'd1);
      chk("bp_hold", result_op, 32'd3);
      chk("bp_ready", 32'(in_ready_op), 32'd0);
    end
    @(posedge clk); #1;
    out_ready_ip = 1'b1;
    send(4'b0000, 32'd10, 32'd20, w);
    chk("bp_same_edge_accept", 32'(w), 32'd0);
    drain();

    // Throughput: 8 back-to-back adds
    for (int i = 0; i < 8; i++) begin
      aluctrl_ip  = 4'b0000;
      op_a_ip     = 32'(i * 3);
      op_b_ip     = 32'h100;
      in_valid_ip = 1'b1;
      @(negedge clk);
      chk("b2b_ready", 32'(in_ready_op), 32'd1);
      @(posedge clk); #1;
    end
    in_valid_ip = 1'b0;
    drain();

    // Illegal code, then a legal op clears the flag
    send(4'b1001, 32'h12345678, 32'h9, w);        drain();
    send(4'b0110, 32'h1, 32'h2, w);               drain();

    // Random mix including shifts of any amount
    for (int i = 0; i < 12; i++) begin
      send(ops[$urandom_range(0, 10)], $urandom, $urandom, w);
      drain();
    end

    // Reset mid-shift aborts the operation
    send(4'b0001, 32'h1, 32'd20, w);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid_op), 32'd0);
    chk("midrst_result", result_op, 32'h0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", 32'(in_ready_op), 32'd1);
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid_op) stale++;
    end
    chk("postrst_stale", 32'(stale), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
